// File: rtl/rom_dl_writer.sv
// ioctl download to ddram bridge: FIFO-buffered 16-bit words, toggle-handshake writes, ROM size/header report.
// Build option: define ROM_BITSWAP_EN to enable per-byte bit reversal controlled by swap_bits.
//
// state  | meaning
// IDLE   | waiting for FIFO data or end of download
// ISSUE  | write request toggled, waiting for wr_ack to match wr_req
// FINISH | download committed, done pulse, report latched the cycle before
module rom_dl_writer #(
    parameter int DEPTH = 4,
    parameter int AW    = 24
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [15:0]   dl_data,
    output logic          dl_wait,
    input  logic          swap_bits,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          wr_req,
    input  logic          wr_ack,
    output logic [AW-1:0] rom_size,
    output logic          hdr_present,
    output logic [AW-1:0] rd_offset,
    output logic          done,
    output logic          overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0]   WAIT_CNT = (PW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] CNT_MAX  = {{(AW-1){1'b1}}, 1'b0};
    localparam logic [AW-1:0] HDR_OFF  = AW'(512);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FINISH} state_t;

    state_t        state, state_next;
    logic          dl_active_q;
    logic          start;
    logic          pending;
    logic          discard;
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count, count_next;
    logic [AW-1:0] byte_cnt;
    logic [15:0]   din;
    logic          empty, full, hs_idle;
    logic          push, pop, issue_done, finish_go;

`ifdef ROM_BITSWAP_EN
    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign din = swap_bits ? {rev8(dl_data[15:8]), rev8(dl_data[7:0])} : dl_data;
`else
    logic swap_bits_unused;
    assign swap_bits_unused = swap_bits;
    assign din = dl_data;
`endif

    assign start   = dl_active & ~dl_active_q;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign hs_idle = (wr_req == wr_ack);
    assign push    = dl_wr & ~full & ~start;

    always_comb begin
        if (start) count_next = '0;
        else       count_next = count + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!start) begin
                    if (!empty && hs_idle)                    state_next = S_ISSUE;
                    else if (!dl_active && empty && pending)  state_next = S_FINISH;
                end
            end
            S_ISSUE:  if (hs_idle) state_next = S_IDLE;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        issue_done = 1'b0;
        finish_go  = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!start) begin
                    if (!empty && hs_idle)                    pop = 1'b1;
                    else if (!dl_active && empty && pending)  finish_go = 1'b1;
                end
            end
            S_ISSUE:  issue_done = hs_idle;
            S_FINISH: done = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (push) mem[wptr] <= din;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_active_q <= 1'b0;
            pending     <= 1'b0;
            discard     <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            dl_wait     <= 1'b0;
            byte_cnt    <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_req      <= 1'b0;
            rom_size    <= '0;
            hdr_present <= 1'b0;
            rd_offset   <= '0;
            overflow    <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            count       <= count_next;
            dl_wait     <= (count_next >= WAIT_CNT);

            // A handshake in flight at download start is allowed to finish but must not move the address.
            if (start && state == S_ISSUE && !hs_idle) discard <= 1'b1;
            else if (issue_done)                       discard <= 1'b0;

            if (start) begin
                pending     <= 1'b1;
                wptr        <= '0;
                rptr        <= '0;
                byte_cnt    <= '0;
                wr_addr     <= '0;
                overflow    <= 1'b0;
                hdr_present <= 1'b0;
                rd_offset   <= '0;
            end else begin
                if (push) wptr <= wptr + PW'(1);
                if (pop)  rptr <= rptr + PW'(1);
                if (push && byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + AW'(2);
                if (dl_wr && full)               overflow <= 1'b1;
                if (issue_done && !discard)      wr_addr  <= wr_addr + AW'(2);
                if (finish_go) begin
                    rom_size    <= byte_cnt;
                    hdr_present <= byte_cnt[9];
                    rd_offset   <= byte_cnt[9] ? HDR_OFF : '0;
                end
                if (state == S_FINISH) pending <= 1'b0;
            end

            if (pop) begin
                wr_data <= mem[rptr];
                wr_req  <= ~wr_req;
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_writer.sv
// Scoreboard bench for rom_dl_writer: stimulus queues expected writes/done reports, a negedge monitor checks them.
module tb_rom_dl_writer;
    localparam int AW = 24;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          dl_active = 1'b0;
    logic          dl_wr = 1'b0;
    logic [15:0]   dl_data = '0;
    logic          swap_bits = 1'b0;
    logic          wr_ack;
    logic          dl_wait;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_req;
    logic [AW-1:0] rom_size;
    logic          hdr_present;
    logic [AW-1:0] rd_offset;
    logic          done;
    logic          overflow;

    rom_dl_writer #(.DEPTH(4), .AW(AW)) dut (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_data(dl_data), .dl_wait(dl_wait), .swap_bits(swap_bits),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_req(wr_req), .wr_ack(wr_ack),
        .rom_size(rom_size), .hdr_present(hdr_present), .rd_offset(rd_offset),
        .done(done), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // ddram model: acknowledges ack_delay cycles after each request toggle
    int ack_delay = 3;
    int ack_cnt;
    always @(posedge clk_sys) begin
        if (reset) begin
            wr_ack  <= 1'b0;
            ack_cnt <= 0;
        end else if (wr_req != wr_ack) begin
            if (ack_cnt >= ack_delay - 1) begin
                wr_ack  <= wr_req;
                ack_cnt <= 0;
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_exp_t;

    typedef struct packed {
        logic [AW-1:0] size;
        logic          hdr;
        logic [AW-1:0] off;
        logic          ovf;
    } done_exp_t;

    wr_exp_t   exp_wr_q[$];
    done_exp_t exp_done_q[$];
    wr_exp_t   we;
    done_exp_t de;

    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic          wait_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor
    logic prev_req = 1'b0;
    logic rst_q = 1'b1;
    logic done_q = 1'b0;
    always @(negedge clk_sys) begin
        if (dl_wait) wait_seen = 1'b1;
        if (reset || rst_q) begin
            prev_req = wr_req;
            rst_q    = reset;
            done_q   = 1'b0;
        end else begin
            if (wr_req != prev_req) begin
                prev_req = wr_req;
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=0x%0h data=0x%0h at %0t", wr_addr, wr_data, $time);
                end else begin
                    we = exp_wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(we.addr));
                    check("wr_data", 32'(wr_data), 32'(we.data));
                end
                last_addr = wr_addr;
            end
            if (done) begin
                check("done_width", 32'(done_q), 32'(0));
                check("done_after_ack", 32'(wr_ack), 32'(wr_req));
                if (exp_done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done rom_size=0x%0h at %0t", rom_size, $time);
                end else begin
                    de = exp_done_q.pop_front();
                    check("rom_size", 32'(rom_size), 32'(de.size));
                    check("hdr_present", 32'(hdr_present), 32'(de.hdr));
                    check("rd_offset", 32'(rd_offset), 32'(de.off));
                    check("overflow", 32'(overflow), 32'(de.ovf));
                end
            end
            done_q = done;
        end
    end

    task automatic push_word(input logic [15:0] d, input logic honor, input logic exp_wr, input logic [15:0] exp_d);
        int guard = 0;
        if (honor) begin
            while (dl_wait && guard < 1000) begin
                @(posedge clk_sys); #1;
                guard++;
            end
            if (guard >= 1000) begin
                checks++;
                failures++;
                $display("FAIL dl_wait_timeout actual=1 expected=0 at %0t", $time);
            end
        end
        dl_data = d;
        dl_wr   = 1'b1;
        if (exp_wr) begin
            exp_wr_q.push_back('{addr: exp_addr, data: exp_d});
            exp_addr = exp_addr + AW'(2);
        end
        @(posedge clk_sys); #1;
        dl_wr = 1'b0;
    endtask

    task automatic start_dl();
        dl_active = 1'b1;
        exp_addr  = '0;
        @(posedge clk_sys); #1;
    endtask

    task automatic end_dl(input logic [AW-1:0] size, input logic hdr, input logic [AW-1:0] off, input logic ovf);
        dl_active = 1'b0;
        exp_done_q.push_back('{size: size, hdr: hdr, off: off, ovf: ovf});
        @(posedge clk_sys); #1;
    endtask

    task automatic wait_quiet(input int limit);
        int n = 0;
        while ((exp_wr_q.size() != 0 || exp_done_q.size() != 0) && n < limit) begin
            @(posedge clk_sys); #1;
            n++;
        end
        if (exp_wr_q.size() != 0 || exp_done_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending_writes=%0d pending_done=%0d expected=0", exp_wr_q.size(), exp_done_q.size());
            exp_wr_q.delete();
            exp_done_q.delete();
        end
        repeat (5) @(posedge clk_sys);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_dl_wait"}, 32'(dl_wait), 32'(0));
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
        check({tag, "_wr_data"}, 32'(wr_data), 32'(0));
        check({tag, "_wr_req"}, 32'(wr_req), 32'(0));
        check({tag, "_rom_size"}, 32'(rom_size), 32'(0));
        check({tag, "_hdr_present"}, 32'(hdr_present), 32'(0));
        check({tag, "_rd_offset"}, 32'(rd_offset), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_overflow"}, 32'(overflow), 32'(0));
    endtask

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [15:0] swap_exp;
`ifdef ROM_BITSWAP_EN
        swap_exp = 16'h800F;
`else
        swap_exp = 16'h01F0;
`endif
        repeat (3) @(posedge clk_sys);
        #1;
        check_outputs_zero("init");
        reset = 1'b0;
        @(posedge clk_sys); #1;

        // 8 words back-to-back, HPS honours dl_wait
        ack_delay = 3;
        wait_seen = 1'b0;
        start_dl();
        for (int i = 1; i <= 8; i++) push_word(16'(i), 1'b1, 1'b1, 16'(i));
        end_dl(AW'(16), 1'b0, '0, 1'b0);
        wait_quiet(2000);
        check("dl_wait_seen", 32'(wait_seen), 32'(1));

        // bit swap of each byte
        start_dl();
        swap_bits = 1'b1;
        push_word(16'h01F0, 1'b0, 1'b1, swap_exp);
        swap_bits = 1'b0;
        end_dl(AW'(2), 1'b0, '0, 1'b0);
        wait_quiet(200);

        // download with a 512-byte header: 0x600 bytes
        ack_delay = 1;
        start_dl();
        for (int i = 0; i < 768; i++) push_word(16'(i * 3 + 7), 1'b1, 1'b1, 16'(i * 3 + 7));
        end_dl(AW'(24'h600), 1'b1, AW'(24'h200), 1'b0);
        wait_quiet(10000);
        check("last_wr_addr", 32'(last_addr), 32'h5FE);

        // restart while a handshake is outstanding, then overfill the FIFO
        ack_delay = 50;
        start_dl();
        push_word(16'h1111, 1'b0, 1'b1, 16'h1111);
        repeat (3) @(posedge clk_sys);
        #1;
        dl_active = 1'b0;
        @(posedge clk_sys); #1;
        start_dl();
        for (int i = 1; i <= 5; i++) push_word(16'(16'h2000 + i), 1'b0, (i <= 4), 16'(16'h2000 + i));
        check("overflow_sticky", 32'(overflow), 32'(1));
        check("dl_wait_full", 32'(dl_wait), 32'(1));
        end_dl(AW'(8), 1'b0, '0, 1'b1);
        wait_quiet(2000);

        // reset while ISSUE is waiting with 2 words queued
        ack_delay = 50;
        start_dl();
        push_word(16'h4001, 1'b0, 1'b1, 16'h4001);
        push_word(16'h4002, 1'b0, 1'b0, 16'h0);
        push_word(16'h4003, 1'b0, 1'b0, 16'h0);
        repeat (2) @(posedge clk_sys);
        #1;
        reset     = 1'b1;
        dl_active = 1'b0;
        @(posedge clk_sys); #1;
        check_outputs_zero("midreset");
        reset = 1'b0;
        repeat (10) @(posedge clk_sys);
        #1;
        ack_delay = 3;
        start_dl();
        push_word(16'h3333, 1'b0, 1'b1, 16'h3333);
        end_dl(AW'(2), 1'b0, '0, 1'b0);
        wait_quiet(200);

        // dl_active falls with 3 words still queued
        ack_delay = 3;
        start_dl();
        for (int i = 1; i <= 4; i++) push_word(16'(16'h5000 + i), 1'b0, 1'b1, 16'(16'h5000 + i));
        end_dl(AW'(8), 1'b0, '0, 1'b0);
        wait_quiet(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
